// File: rtl/mod_video_timing.sv
// mod_video_timing: free-running raster timing generator.
// Produces the pixel coordinates, the active-video flag, horizontal and
// vertical sync, and a once-per-frame latch strobe. All outputs are
// registered and describe the same (x, y) in the same cycle.
// Build option: define MOD_VIDEO_TIMING_SYNC_POS_EN for active-high syncs.
// Without it, both syncs are active-low, which matches 640x480 VESA.
module mod_video_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       in_pix_clk,
   input  logic       in_rst_n,
   output logic [9:0] out_pix_x,
   output logic [9:0] out_pix_y,
   output logic       out_active,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       out_latch
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Both counters are 10 bits wide, so neither total may exceed 1024.
   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
         $error("mod_video_timing: H_TOTAL and V_TOTAL must not exceed 1024");
      end
   endgenerate

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_END    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
   localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef MOD_VIDEO_TIMING_SYNC_POS_EN
   localparam logic SYNC_ON = 1'b1;
`else
   localparam logic SYNC_ON = 1'b0;
`endif

   logic [9:0] x_nxt;
   logic [9:0] y_nxt;
   logic       x_wrap;
   logic       active_nxt;
   logic       hsync_nxt;
   logic       vsync_nxt;
   logic       latch_nxt;

   // Next-state counters: x every cycle, y only when x wraps.
   always_comb begin
      x_wrap = (out_pix_x == H_LAST);
      x_nxt  = x_wrap ? 10'd0 : out_pix_x + 10'd1;
      y_nxt  = out_pix_y;
      if (x_wrap) begin
         y_nxt = (out_pix_y == V_LAST) ? 10'd0 : out_pix_y + 10'd1;
      end
   end

   // Flags decoded from the next-state position so they align with it.
   always_comb begin
      active_nxt = (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);
      hsync_nxt  = ((x_nxt >= H_SYNC_FIRST) && (x_nxt <= H_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
      vsync_nxt  = ((y_nxt >= V_SYNC_FIRST) && (y_nxt <= V_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
      latch_nxt  = (x_nxt == 10'd0) && (y_nxt == V_ACT_END);
   end

   // Output register stage. Reset parks the counters on the last pixel of
   // the frame so the first edge after release lands on (0, 0).
   always_ff @(posedge in_pix_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         out_pix_x  <= H_LAST;
         out_pix_y  <= V_LAST;
         out_active <= 1'b0;
         out_hsync  <= ~SYNC_ON;
         out_vsync  <= ~SYNC_ON;
         out_latch  <= 1'b0;
      end else begin
         out_pix_x  <= x_nxt;
         out_pix_y  <= y_nxt;
         out_active <= active_nxt;
         out_hsync  <= hsync_nxt;
         out_vsync  <= vsync_nxt;
         out_latch  <= latch_nxt;
      end
   end

endmodule
